clock_time_setter: RTL

Automatic time-set controller for the alarm-clock datapath. It drives the clock's manual set inputs (Timeset, Minadv, Hrsadv, Dayadv, DateAdv, MonthAdv) so the clock reaches a requested minute, hour, weekday, date and month. It reads the clock's 7-segment display outputs back, decodes them, and checks its own progress against them. It sits between a host or test controller and the clock top level, in place of the manual buttons.

---
 rtl/clock_time_setter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/clock_time_setter.sv
// Automatic time-set controller: steps the clock's set inputs until the decoded
// 7-segment display shows the requested minute, hour, weekday, date and month.
module clock_time_setter #(
  parameter int unsigned MAX_PASS   = 3,
  parameter int unsigned STEP_LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] tgt_min,
  input  logic [4:0] tgt_hrs,
  input  logic [2:0] tgt_wday,
  input  logic [4:0] tgt_date,
  input  logic [3:0] tgt_mon,
  input  logic [6:0] M1disp,
  input  logic [6:0] M0disp,
  input  logic [6:0] H1disp,
  input  logic [6:0] H0disp,
  input  logic [6:0] D0disp,
  input  logic [6:0] Date1disp,
  input  logic [6:0] Date0disp,
  input  logic [6:0] Month1disp,
  input  logic [6:0] Month0disp,
  output logic       Timeset,
  output logic       Minadv,
  output logic       Hrsadv,
  output logic       Dayadv,
  output logic       DateAdv,
  output logic       MonthAdv,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned SW = $clog2(STEP_LIMIT + 1);
  localparam int unsigned PW = $clog2(MAX_PASS + 1);

  // CHECK/PULSE/SETTLE are shared by all fields; fld selects the field being set.
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PULSE, S_SETTLE, S_VERIFY, S_DONE} state_t;
  typedef enum logic [2:0] {F_MIN, F_HRS, F_WDAY, F_DATE, F_MON} field_t;

  state_t        state, state_d;
  field_t        fld, fld_d;
  logic [SW-1:0] step, step_d;
  logic [PW-1:0] pass, pass_d;
  logic          err_d, load;
  logic [4:0]    adv, adv_d;
  logic [5:0]    t_min;
  logic [4:0]    t_hrs;
  logic [2:0]    t_wday;
  logic [4:0]    t_date;
  logic [3:0]    t_mon;
  logic [7:0]    min_f, hrs_f, date_f, mon_f;
  logic [4:0]    wday_f;
  logic [4:0]    match;
  logic          tgt_ok, in_op;

  // returns {valid, digit}
  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    case (s)
      7'h3F:   return 5'h10;
      7'h06:   return 5'h11;
      7'h5B:   return 5'h12;
      7'h4F:   return 5'h13;
      7'h66:   return 5'h14;
      7'h6D:   return 5'h15;
      7'h7D:   return 5'h16;
      7'h07:   return 5'h17;
      7'h7F:   return 5'h18;
      7'h6F:   return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

  // returns {valid, tens*10 + units}; a blank tens digit reads as zero
  function automatic logic [7:0] field_dec(input logic [6:0] tens, input logic [6:0] units);
    logic [4:0] t;
    logic [4:0] u;
    t = (tens == 7'h00) ? 5'h10 : seg_dec(tens);
    u = seg_dec(units);
    return {t[4] & u[4], 7'(t[3:0]) * 7'd10 + 7'(u[3:0])};
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m);
    case (m)
      4'd2:                      return 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  assign min_f  = field_dec(M1disp, M0disp);
  assign hrs_f  = field_dec(H1disp, H0disp);
  assign wday_f = seg_dec(D0disp);
  assign date_f = field_dec(Date1disp, Date0disp);
  assign mon_f  = field_dec(Month1disp, Month0disp);

  assign match[0] = min_f[7]  && (min_f[6:0]  == {1'b0, t_min});
  assign match[1] = hrs_f[7]  && (hrs_f[6:0]  == {2'b0, t_hrs});
  assign match[2] = wday_f[4] && (wday_f[3:0] == {1'b0, t_wday});
  assign match[3] = date_f[7] && (date_f[6:0] == {2'b0, t_date});
  assign match[4] = mon_f[7]  && (mon_f[6:0]  == {3'b0, t_mon});

  assign tgt_ok = (tgt_min <= 6'd59) && (tgt_hrs <= 5'd23) && (tgt_wday <= 3'd6) &&
                  (tgt_mon >= 4'd1) && (tgt_mon <= 4'd12) &&
                  (tgt_date >= 5'd1) && (tgt_date <= month_len(tgt_mon));

  always_comb begin
    state_d = state;
    fld_d   = fld;
    step_d  = step;
    pass_d  = pass;
    err_d   = err;
    load    = 1'b0;
    if (abort && state != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (tgt_ok) begin
              err_d   = 1'b0;
              load    = 1'b1;
              fld_d   = F_MIN;
              step_d  = '0;
              pass_d  = '0;
              state_d = S_CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (match[fld]) begin
            step_d = '0;
            if (fld == F_MON) state_d = S_VERIFY;
            else              fld_d   = field_t'(fld + 3'd1);
          end else if (step == SW'(STEP_LIMIT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_PULSE;
          end
        end
        S_PULSE: begin
          step_d  = step + SW'(1);
          state_d = S_SETTLE;
        end
        S_SETTLE: state_d = S_CHECK;
        S_VERIFY: begin
          if (&match) begin
            state_d = S_DONE;
          end else if (32'(pass) + 32'd1 >= MAX_PASS) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            pass_d  = pass + PW'(1);
            fld_d   = F_MIN;
            step_d  = '0;
            state_d = S_CHECK;
          end
        end
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
    in_op = (state_d == S_CHECK) || (state_d == S_PULSE) ||
            (state_d == S_SETTLE) || (state_d == S_VERIFY);
    adv_d = (state_d == S_PULSE) ? (5'b00001 << fld_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      fld     <= F_MIN;
      step    <= '0;
      pass    <= '0;
      err     <= 1'b0;
      Timeset <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      adv     <= '0;
      t_min   <= '0;
      t_hrs   <= '0;
      t_wday  <= '0;
      t_date  <= '0;
      t_mon   <= '0;
    end else begin
      state   <= state_d;
      fld     <= fld_d;
      step    <= step_d;
      pass    <= pass_d;
      err     <= err_d;
      Timeset <= in_op;
      busy    <= in_op;
      done    <= (state_d == S_DONE);
      adv     <= adv_d;
      if (load) begin
        t_min  <= tgt_min;
        t_hrs  <= tgt_hrs;
        t_wday <= tgt_wday;
        t_date <= tgt_date;
        t_mon  <= tgt_mon;
      end
    end
  end

  assign Minadv   = adv[0];
  assign Hrsadv   = adv[1];
  assign Dayadv   = adv[2];
  assign DateAdv  = adv[3];
  assign MonthAdv = adv[4];

endmodule
